midi_message_parser: RTL and testbench

- Byte-stream MIDI 1.0 decoder. Sits directly downstream of the MIDI UART receiver in the synthesizer block and consumes its 8-bit data / valid strobe.
- Assembles complete channel-voice messages, tracks running status, discards SysEx and system-common traffic, and forwards real-time bytes.
- Emits one registered message strobe per decoded event to the voice-allocation stage that follows.

---
 rtl/midi_pkg.sv | 40 ++++
 rtl/midi_message_parser_if.sv | 26 ++
 rtl/midi_message_parser.sv | 212 +++++++++++++++++++++
 tb/tb_midi_message_parser.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// MIDI 1.0 parser shared definitions: message encodings, status constants, helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package midi_pkg;

    typedef enum logic [2:0] {
        MSG_NOTE_OFF = 3'd0,
        MSG_NOTE_ON  = 3'd1,
        MSG_POLY_AT  = 3'd2,
        MSG_CC       = 3'd3,
        MSG_PROG     = 3'd4,
        MSG_CH_AT    = 3'd5,
        MSG_PITCH    = 3'd6,
        MSG_REALTIME = 3'd7
    } msg_type_e;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_D1 = 3'd1,
        S_WAIT_D2 = 3'd2,
        S_SKIP    = 3'd3,
        S_SYSEX   = 3'd4
    } parse_state_e;

    localparam logic [3:0] ST_NOTE_ON  = 4'h9;
    localparam logic [7:0] SYSEX_START = 8'hF0;
    localparam logic [7:0] SYSEX_END   = 8'hF7;
    localparam logic [7:0] RT_BASE     = 8'hF8;

    // Program change (Cx) and channel pressure (Dx) carry one data byte, all others two.
    function automatic logic [1:0] data_count(input logic [3:0] status_hi);
        return (status_hi == 4'hC || status_hi == 4'hD) ? 2'd1 : 2'd2;
    endfunction

    // Channel status nibbles 8..E map onto message types 0..6.
    function automatic msg_type_e msg_type(input logic [3:0] status_hi);
        return msg_type_e'(status_hi[2:0]);
    endfunction

endpackage

// File: rtl/midi_message_parser_if.sv
// Byte-in / message-out bundle between UART receiver, parser and voice allocator.
// Latency: n/a (wiring only).
// Backpressure: none; bytes are strobes and messages are strobes, nothing stalls.
interface midi_message_parser_if;
    logic [7:0] iRd;
    logic       iVd;
    logic [2:0] oMsgType;
    logic [3:0] oMsgCh;
    logic [6:0] oMsgD1;
    logic [6:0] oMsgD2;
    logic       oMsgVd;
    logic [7:0] oErrCnt;
    logic       oBusy;

    // Upstream side: supplies bytes, observes decoded messages.
    modport master (
        output iRd, iVd,
        input  oMsgType, oMsgCh, oMsgD1, oMsgD2, oMsgVd, oErrCnt, oBusy
    );

    // Parser side.
    modport slave (
        input  iRd, iVd,
        output oMsgType, oMsgCh, oMsgD1, oMsgD2, oMsgVd, oErrCnt, oBusy
    );
endinterface

// File: rtl/midi_message_parser.sv
// MIDI 1.0 byte-stream decoder: channel voice messages with running status, real-time passthrough.
// Latency: message strobe 1 clock after the completing (or real-time) byte strobe.
// Backpressure: none; input bytes arrive at most every 2 clocks and are always accepted.
module midi_message_parser
    import midi_pkg::*;
#(
    parameter int pTimeoutCycles = 1000000,
    parameter int pTimeoutWidth  = 20,
    parameter int pVel0AsNoteOff = 1
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    midi_message_parser_if.slave bus
);

    localparam bit                     TMO_EN   = (pTimeoutCycles != 0);
    localparam bit                     VEL0_OFF = (pVel0AsNoteOff != 0);
    localparam logic [pTimeoutWidth-1:0] TMO_LAST =
        pTimeoutWidth'((pTimeoutCycles > 0) ? pTimeoutCycles - 1 : 0);

    parse_state_e             state_q, state_d;
    logic                     rs_vld_q, rs_vld_d;
    logic [3:0]               rs_st_q, rs_st_d;
    logic [3:0]               rs_ch_q, rs_ch_d;
    logic [6:0]               d1_q, d1_d;
    logic [1:0]               skip_q, skip_d;
    logic [pTimeoutWidth-1:0] tmo_q, tmo_d;
    msg_type_e                msg_type_q, msg_type_d;
    logic [3:0]               msg_ch_q, msg_ch_d;
    logic [6:0]               msg_d1_q, msg_d1_d;
    logic [6:0]               msg_d2_q, msg_d2_d;
    logic                     msg_vld_q, msg_vld_d;
    logic [7:0]               err_q, err_d;

    logic       is_rt, is_status, is_data, counting;
    logic       emit;
    logic [6:0] emit_d1, emit_d2;
    logic [1:0] err_inc;
    logic [8:0] err_sum;

    assign is_rt     = bus.iVd && (bus.iRd >= RT_BASE);
    assign is_status = bus.iVd && bus.iRd[7] && (bus.iRd < RT_BASE);
    assign is_data   = bus.iVd && !bus.iRd[7];
    assign counting  = (state_q == S_WAIT_D1) || (state_q == S_WAIT_D2) || (state_q == S_SKIP);

    // Next-state: byte classification, running status, message assembly, timeout, error count.
    always_comb begin
        state_d    = state_q;
        rs_vld_d   = rs_vld_q;
        rs_st_d    = rs_st_q;
        rs_ch_d    = rs_ch_q;
        d1_d       = d1_q;
        skip_d     = skip_q;
        tmo_d      = tmo_q;
        msg_type_d = msg_type_q;
        msg_ch_d   = msg_ch_q;
        msg_d1_d   = msg_d1_q;
        msg_d2_d   = msg_d2_q;
        msg_vld_d  = 1'b0;
        err_inc    = 2'd0;
        emit       = 1'b0;
        emit_d1    = 7'd0;
        emit_d2    = 7'd0;
        err_sum    = 9'd0;

        if (is_rt) begin
            // Real-time bytes are transparent: only the output message changes.
            msg_vld_d  = 1'b1;
            msg_type_d = MSG_REALTIME;
            msg_ch_d   = bus.iRd[3:0];
            msg_d1_d   = 7'd0;
            msg_d2_d   = 7'd0;
        end else if (is_status) begin
            tmo_d   = '0;
            skip_d  = 2'd0;
            state_d = S_IDLE;
            // A status byte cutting into a partial message loses that message.
            if (state_q == S_WAIT_D1 || state_q == S_WAIT_D2) begin
                err_inc = err_inc + 2'd1;
            end
            if (bus.iRd < SYSEX_START) begin
                rs_vld_d = 1'b1;
                rs_st_d  = bus.iRd[7:4];
                rs_ch_d  = bus.iRd[3:0];
                state_d  = S_WAIT_D1;
            end else begin
                case (bus.iRd)
                    SYSEX_START: begin
                        rs_vld_d = 1'b0;
                        state_d  = S_SYSEX;
                    end
                    8'hF1, 8'hF3: begin
                        rs_vld_d = 1'b0;
                        skip_d   = 2'd1;
                        state_d  = S_SKIP;
                    end
                    8'hF2: begin
                        rs_vld_d = 1'b0;
                        skip_d   = 2'd2;
                        state_d  = S_SKIP;
                    end
                    SYSEX_END: begin
                        if (state_q != S_SYSEX) begin
                            err_inc = err_inc + 2'd1;
                        end
                    end
                    default: begin
                        rs_vld_d = 1'b0;
                    end
                endcase
            end
        end else if (is_data) begin
            tmo_d = '0;
            case (state_q)
                S_IDLE, S_WAIT_D1: begin
                    if (rs_vld_q) begin
                        if (data_count(rs_st_q) == 2'd1) begin
                            emit    = 1'b1;
                            emit_d1 = bus.iRd[6:0];
                            state_d = S_IDLE;
                        end else begin
                            d1_d    = bus.iRd[6:0];
                            state_d = S_WAIT_D2;
                        end
                    end else begin
                        err_inc = err_inc + 2'd1;
                    end
                end
                S_WAIT_D2: begin
                    emit    = 1'b1;
                    emit_d1 = d1_q;
                    emit_d2 = bus.iRd[6:0];
                    state_d = S_IDLE;
                end
                S_SKIP: begin
                    skip_d = skip_q - 2'd1;
                    if (skip_q == 2'd1) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                end
            endcase
        end else if (TMO_EN && counting) begin
            // Abort a stalled partial message; running status survives.
            if (tmo_q == TMO_LAST) begin
                tmo_d   = '0;
                skip_d  = 2'd0;
                state_d = S_IDLE;
                err_inc = err_inc + 2'd1;
            end else begin
                tmo_d = tmo_q + pTimeoutWidth'(1);
            end
        end

        if (emit) begin
            msg_vld_d  = 1'b1;
            msg_ch_d   = rs_ch_q;
            msg_d1_d   = emit_d1;
            msg_d2_d   = emit_d2;
            msg_type_d = msg_type(rs_st_q);
            if (VEL0_OFF && rs_st_q == ST_NOTE_ON && emit_d2 == 7'd0) begin
                msg_type_d = MSG_NOTE_OFF;
            end
        end

        err_sum = {1'b0, err_q} + {7'd0, err_inc};
        err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q    <= S_IDLE;
            rs_vld_q   <= 1'b0;
            rs_st_q    <= 4'd0;
            rs_ch_q    <= 4'd0;
            d1_q       <= 7'd0;
            skip_q     <= 2'd0;
            tmo_q      <= '0;
            msg_type_q <= MSG_NOTE_OFF;
            msg_ch_q   <= 4'd0;
            msg_d1_q   <= 7'd0;
            msg_d2_q   <= 7'd0;
            msg_vld_q  <= 1'b0;
            err_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            rs_vld_q   <= rs_vld_d;
            rs_st_q    <= rs_st_d;
            rs_ch_q    <= rs_ch_d;
            d1_q       <= d1_d;
            skip_q     <= skip_d;
            tmo_q      <= tmo_d;
            msg_type_q <= msg_type_d;
            msg_ch_q   <= msg_ch_d;
            msg_d1_q   <= msg_d1_d;
            msg_d2_q   <= msg_d2_d;
            msg_vld_q  <= msg_vld_d;
            err_q      <= err_d;
        end
    end

    assign bus.oMsgType = msg_type_q;
    assign bus.oMsgCh   = msg_ch_q;
    assign bus.oMsgD1   = msg_d1_q;
    assign bus.oMsgD2   = msg_d2_q;
    assign bus.oMsgVd   = msg_vld_q;
    assign bus.oErrCnt  = err_q;
    assign bus.oBusy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_midi_message_parser.sv
// Bench for midi_message_parser: directed sequences plus random byte streams vs a reference model.
// Latency: expects each message strobe exactly one clock after its completing byte.
// Backpressure: none; bytes are issued no faster than one per two clocks.
module tb_midi_message_parser;

    localparam int TMO = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    midi_message_parser_if bus();

    midi_message_parser #(
        .pTimeoutCycles (TMO),
        .pTimeoutWidth  (8),
        .pVel0AsNoteOff (1)
    ) dut (
        .iCLK (clk),
        .iRST (rst),
        .bus  (bus)
    );

    typedef struct {
        int         cyc;
        logic [2:0] t;
        logic [3:0] ch;
        logic [6:0] d1;
        logic [6:0] d2;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   n_msg  = 0;

    // Reference model: running status byte, collected data bytes, bytes left to skip.
    int   m_rs   = -1;
    bit   m_coll = 0;
    int   m_part[$];
    int   m_skip = 0;
    bit   m_sysex = 0;
    int   m_err  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_rs = -1; m_coll = 0; m_part.delete(); m_skip = 0; m_sysex = 0; m_err = 0;
        q.delete();
    endfunction

    function automatic void model_byte(input logic [7:0] b, input int issue_cyc);
        exp_t e;
        int   hi, need;
        bit   was_sysex;
        if (b >= 8'hF8) begin
            e.cyc = issue_cyc + 1; e.t = 3'd7; e.ch = b[3:0]; e.d1 = 7'd0; e.d2 = 7'd0;
            q.push_back(e);
        end else if (b[7]) begin
            was_sysex = m_sysex;
            if (m_coll) m_err++;
            m_coll = 0; m_part.delete(); m_sysex = 0; m_skip = 0;
            if (b < 8'hF0) begin
                m_rs = b; m_coll = 1;
            end else if (b == 8'hF0) begin
                m_rs = -1; m_sysex = 1;
            end else if (b == 8'hF1 || b == 8'hF3) begin
                m_rs = -1; m_skip = 1;
            end else if (b == 8'hF2) begin
                m_rs = -1; m_skip = 2;
            end else if (b == 8'hF7) begin
                if (!was_sysex) m_err++;
            end else begin
                m_rs = -1;
            end
        end else begin
            if (m_sysex) begin
            end else if (m_skip > 0) begin
                m_skip--;
            end else if (m_rs < 0) begin
                m_err++;
            end else begin
                m_part.push_back(int'(b));
                hi   = m_rs / 16;
                need = (hi == 12 || hi == 13) ? 1 : 2;
                if (m_part.size() == need) begin
                    e.cyc = issue_cyc + 1;
                    e.ch  = 4'(m_rs % 16);
                    e.d1  = 7'(m_part[0]);
                    e.d2  = (need == 2) ? 7'(m_part[1]) : 7'd0;
                    e.t   = 3'(hi - 8);
                    if (hi == 9 && e.d2 == 7'd0) e.t = 3'd0;
                    q.push_back(e);
                    m_part.delete();
                    m_coll = 0;
                end else begin
                    m_coll = 1;
                end
            end
        end
        if (m_err > 255) m_err = 255;
    endfunction

    function automatic void model_timeout();
        if (m_coll || m_skip > 0) m_err++;
        m_coll = 0; m_part.delete(); m_skip = 0;
        if (m_err > 255) m_err = 255;
    endfunction

    function automatic int model_busy();
        return (m_coll || m_skip > 0 || m_sysex) ? 1 : 0;
    endfunction

    // Monitor: every strobe must match the oldest expected message, at the expected cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.oMsgVd) begin
            n_msg++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_msg actual type %0d ch %0h required no strobe", bus.oMsgType, bus.oMsgCh);
            end else begin
                e = q.pop_front();
                check("msg_cycle", cyc, e.cyc);
                check("msg_type", int'(bus.oMsgType), int'(e.t));
                check("msg_ch", int'(bus.oMsgCh), int'(e.ch));
                if (e.t != 3'd7) check("msg_d1", int'(bus.oMsgD1), int'(e.d1));
                check("msg_d2", int'(bus.oMsgD2), int'(e.d2));
            end
        end
    end

    task automatic send(input logic [7:0] b, input int gap);
        @(negedge clk);
        bus.iRd = b;
        bus.iVd = 1'b1;
        model_byte(b, cyc);
        @(negedge clk);
        bus.iVd = 1'b0;
        check("err_cnt", int'(bus.oErrCnt), m_err);
        check("busy", int'(bus.oBusy), model_busy());
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.iVd = 1'b0;
        bus.iRd = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_type", int'(bus.oMsgType), 0);
        check("rst_ch", int'(bus.oMsgCh), 0);
        check("rst_d1", int'(bus.oMsgD1), 0);
        check("rst_d2", int'(bus.oMsgD2), 0);
        check("rst_vld", int'(bus.oMsgVd), 0);
        check("rst_err", int'(bus.oErrCnt), 0);
        check("rst_busy", int'(bus.oBusy), 0);
        model_reset();
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic expect_msgs(input string name, input int base, input int n);
        @(negedge clk);
        @(negedge clk);
        check(name, n_msg - base, n);
    endtask

    initial begin
        int         base;
        int         r;
        logic [7:0] b;
        logic [7:0] seq1[3]  = '{8'h90, 8'h3C, 8'h64};
        logic [7:0] seq2[5]  = '{8'h93, 8'h3C, 8'h64, 8'h3E, 8'h70};
        logic [7:0] seq3[5]  = '{8'h91, 8'h40, 8'h00, 8'hC5, 8'h07};
        logic [7:0] seq4[5]  = '{8'h90, 8'hF8, 8'h3C, 8'hFE, 8'h64};
        logic [7:0] seq5[6]  = '{8'hF0, 8'h7E, 8'h01, 8'h02, 8'hF7, 8'h3C};

        bus.iVd = 1'b0;
        bus.iRd = 8'h00;
        do_reset();

        base = n_msg;
        foreach (seq1[i]) send(seq1[i], 0);
        expect_msgs("note_on_count", base, 1);

        do_reset();
        base = n_msg;
        foreach (seq2[i]) send(seq2[i], 1);
        expect_msgs("running_status_count", base, 2);
        check("running_status_err", int'(bus.oErrCnt), 0);

        do_reset();
        base = n_msg;
        foreach (seq3[i]) send(seq3[i], 0);
        expect_msgs("vel0_prog_count", base, 2);

        do_reset();
        base = n_msg;
        foreach (seq4[i]) send(seq4[i], 0);
        expect_msgs("realtime_interleave_count", base, 3);

        do_reset();
        base = n_msg;
        foreach (seq5[i]) send(seq5[i], 2);
        expect_msgs("sysex_count", base, 0);
        check("sysex_err", int'(bus.oErrCnt), 1);

        do_reset();
        base = n_msg;
        send(8'hB0, 0);
        send(8'h07, 0);
        repeat (TMO + 5) @(negedge clk);
        model_timeout();
        check("timeout_err", int'(bus.oErrCnt), 1);
        check("timeout_busy", int'(bus.oBusy), 0);
        send(8'h07, 0);
        send(8'h64, 0);
        expect_msgs("timeout_rs_count", base, 1);

        // Asynchronous reset in the middle of a note-on.
        send(8'h90, 0);
        send(8'h3C, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_type", int'(bus.oMsgType), 0);
        check("arst_ch", int'(bus.oMsgCh), 0);
        check("arst_d1", int'(bus.oMsgD1), 0);
        check("arst_d2", int'(bus.oMsgD2), 0);
        check("arst_err", int'(bus.oErrCnt), 0);
        check("arst_busy", int'(bus.oBusy), 0);
        do_reset();

        // Stray data with no running status drives the error counter into saturation.
        for (int i = 0; i < 300; i++) send(8'h55, 0);
        check("err_saturate", int'(bus.oErrCnt), 255);

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 50)      b = 8'($urandom_range(8'h00, 8'h7F));
            else if (r < 75) b = 8'($urandom_range(8'h80, 8'hEF));
            else if (r < 85) b = 8'($urandom_range(8'hF8, 8'hFF));
            else             b = 8'($urandom_range(8'hF0, 8'hF7));
            send(b, $urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) begin
                repeat (TMO + 5) @(negedge clk);
                model_timeout();
                check("rand_timeout_err", int'(bus.oErrCnt), m_err);
            end
        end

        repeat (5) @(negedge clk);
        check("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
